conv11_feeder: RTL and testbench

CONV11_FEEDER -- requirements
Module: conv11_feeder

---
 rtl/conv11_feeder.sv | 148 ++++++++++++++
 tb/tb_conv11_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv11_feeder.sv
// conv11_feeder: sequences per-channel parameter loads and feature-map reads
// for a 1x1 convolution datapath, with a fixed 2-cycle read-to-enable latency.
module conv11_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int BIAS_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int PIX_NUM    = 64,
    parameter int CH_NUM     = 4,
    localparam int CH_WIDTH  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic                         fm_rd_en,
    output logic [ADDR_WIDTH-1:0]        fm_rd_addr,
    input  logic [DATA_WIDTH-1:0]        fm_rd_data,
    output logic                         par_rd_en,
    output logic [CH_WIDTH-1:0]          par_rd_addr,
    input  logic [DATA_WIDTH-1:0]        weight_in,
    input  logic [BIAS_WIDTH-1:0]        bias_in,
    input  logic [BIAS_WIDTH-1:0]        scale_in,
    output logic                         conv11_en,
    output logic signed [DATA_WIDTH-1:0] data_0_0,
    output logic signed [DATA_WIDTH-1:0] weight_0,
    output logic signed [BIAS_WIDTH-1:0] bias,
    output logic signed [BIAS_WIDTH-1:0] scale,
    output logic [CH_WIDTH-1:0]          ch_idx,
    output logic [ADDR_WIDTH-1:0]        pix_idx
);

    localparam logic [ADDR_WIDTH-1:0] P_LAST = ADDR_WIDTH'(PIX_NUM - 1);
    localparam logic [CH_WIDTH-1:0]   C_LAST = CH_WIDTH'(CH_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAR,
        WAIT_PAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                state, state_nx;
    logic [CH_WIDTH-1:0]   c, c_nx;
    logic [ADDR_WIDTH-1:0] p, p_nx;
    logic                  drain_cnt, drain_nx;
    logic                  cap_par;
    logic                  rd_v;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    always_comb begin
        state_nx    = state;
        c_nx        = c;
        p_nx        = p;
        drain_nx    = 1'b0;
        cap_par     = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        fm_rd_en    = 1'b0;
        fm_rd_addr  = '0;
        par_rd_en   = 1'b0;
        par_rd_addr = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD_PAR;
                    c_nx     = '0;
                end
            end
            LOAD_PAR: begin
                par_rd_en   = 1'b1;
                par_rd_addr = c;
                state_nx    = WAIT_PAR;
            end
            WAIT_PAR: begin
                cap_par  = 1'b1;
                p_nx     = '0;
                state_nx = STREAM;
            end
            STREAM: begin
                if (!stall) begin
                    fm_rd_en   = 1'b1;
                    fm_rd_addr = p;
                    // hold p on the last pixel so it never wraps
                    if (p == P_LAST) state_nx = DRAIN;
                    else p_nx = p + 1'b1;
                end
            end
            DRAIN: begin
                drain_nx = ~drain_cnt;
                if (drain_cnt) begin
                    if (c == C_LAST) begin
                        state_nx = DONE;
                    end else begin
                        c_nx     = c + 1'b1;
                        state_nx = LOAD_PAR;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            c         <= '0;
            p         <= '0;
            drain_cnt <= 1'b0;
            rd_v      <= 1'b0;
            rd_addr_q <= '0;
            conv11_en <= 1'b0;
            data_0_0  <= '0;
            pix_idx   <= '0;
            ch_idx    <= '0;
            weight_0  <= '0;
            bias      <= '0;
            scale     <= '0;
        end else begin
            state     <= state_nx;
            c         <= c_nx;
            p         <= p_nx;
            drain_cnt <= drain_nx;
            rd_v      <= fm_rd_en;
            rd_addr_q <= fm_rd_addr;
            conv11_en <= rd_v;
            // c is stable until the end of DRAIN, so it tags the last reads too
            if (rd_v) begin
                data_0_0 <= fm_rd_data;
                pix_idx  <= rd_addr_q;
                ch_idx   <= c;
            end
            if (cap_par) begin
                weight_0 <= weight_in;
                bias     <= bias_in;
                scale    <= scale_in;
            end
        end
    end

endmodule

// File: tb/tb_conv11_feeder.sv
// tb_conv11_feeder: directed and randomized checks of conv11_feeder against
// an ordered list of expected (pixel, channel) enable events.
module tb_conv11_feeder;

    typedef struct {
        int          cyc;
        logic [7:0]  d;
        logic [7:0]  w;
        logic [31:0] b;
        logic [31:0] s;
        logic [0:0]  ch;
        logic [11:0] pix;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0]  fm [4];
    logic [7:0]  wm [2];
    logic [31:0] bm [2];
    logic [31:0] sm [2];

    logic        a_start, a_stall, a_busy, a_done;
    logic        a_fm_rd_en, a_par_rd_en, a_conv11_en;
    logic [11:0] a_fm_rd_addr, a_pix_idx;
    logic [7:0]  a_fm_data, a_w_in;
    logic [31:0] a_b_in, a_s_in;
    logic [0:0]  a_par_rd_addr, a_ch_idx;
    logic [7:0]  a_data_0_0, a_weight_0;
    logic [31:0] a_bias, a_scale;

    logic        b_start, b_stall, b_busy, b_done;
    logic        b_fm_rd_en, b_par_rd_en, b_conv11_en;
    logic [11:0] b_fm_rd_addr, b_pix_idx;
    logic [7:0]  b_fm_data, b_w_in;
    logic [31:0] b_b_in, b_s_in;
    logic [0:0]  b_par_rd_addr, b_ch_idx;
    logic [7:0]  b_data_0_0, b_weight_0;
    logic [31:0] b_bias, b_scale;

    ev_t a_ev [$];
    ev_t exp_q [$];
    int  a_done_q [$];
    int  b_rd_q [$];
    int  b_conv_q [$];
    int  b_done_q [$];

    conv11_feeder #(.PIX_NUM(4), .CH_NUM(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .stall(a_stall),
        .busy(a_busy), .done(a_done),
        .fm_rd_en(a_fm_rd_en), .fm_rd_addr(a_fm_rd_addr),
        .fm_rd_data(a_fm_data),
        .par_rd_en(a_par_rd_en), .par_rd_addr(a_par_rd_addr),
        .weight_in(a_w_in), .bias_in(a_b_in), .scale_in(a_s_in),
        .conv11_en(a_conv11_en), .data_0_0(a_data_0_0),
        .weight_0(a_weight_0), .bias(a_bias), .scale(a_scale),
        .ch_idx(a_ch_idx), .pix_idx(a_pix_idx)
    );

    conv11_feeder #(.PIX_NUM(1), .CH_NUM(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .stall(b_stall),
        .busy(b_busy), .done(b_done),
        .fm_rd_en(b_fm_rd_en), .fm_rd_addr(b_fm_rd_addr),
        .fm_rd_data(b_fm_data),
        .par_rd_en(b_par_rd_en), .par_rd_addr(b_par_rd_addr),
        .weight_in(b_w_in), .bias_in(b_b_in), .scale_in(b_s_in),
        .conv11_en(b_conv11_en), .data_0_0(b_data_0_0),
        .weight_0(b_weight_0), .bias(b_bias), .scale(b_scale),
        .ch_idx(b_ch_idx), .pix_idx(b_pix_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // one-cycle-latency memories feeding both instances
    always @(posedge clk) begin
        if (a_fm_rd_en) a_fm_data <= fm[int'(a_fm_rd_addr) % 4];
        if (a_par_rd_en) begin
            a_w_in <= wm[a_par_rd_addr];
            a_b_in <= bm[a_par_rd_addr];
            a_s_in <= sm[a_par_rd_addr];
        end
        if (b_fm_rd_en) b_fm_data <= fm[int'(b_fm_rd_addr) % 4];
        if (b_par_rd_en) begin
            b_w_in <= wm[b_par_rd_addr];
            b_b_in <= bm[b_par_rd_addr];
            b_s_in <= sm[b_par_rd_addr];
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (a_conv11_en) begin
            e.cyc = cyc;
            e.d   = a_data_0_0;
            e.w   = a_weight_0;
            e.b   = a_bias;
            e.s   = a_scale;
            e.ch  = a_ch_idx;
            e.pix = a_pix_idx;
            a_ev.push_back(e);
        end
        if (a_done) a_done_q.push_back(cyc);
        if (b_fm_rd_en) b_rd_q.push_back(cyc);
        if (b_conv11_en) b_conv_q.push_back(cyc);
        if (b_done) b_done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // every pixel of every channel, channel-major, with that channel's params
    task automatic build_exp();
        ev_t e;
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                e.cyc = 0;
                e.d   = fm[p];
                e.w   = wm[c];
                e.b   = bm[c];
                e.s   = sm[c];
                e.ch  = 1'(c);
                e.pix = 12'(p);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cmp_events(input string tag);
        int n;
        build_exp();
        chk({tag, "_count"}, 64'(a_ev.size()), 64'(exp_q.size()));
        n = (a_ev.size() < exp_q.size()) ? a_ev.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 64'(a_ev[i].d), 64'(exp_q[i].d));
            chk({tag, "_weight"}, 64'(a_ev[i].w), 64'(exp_q[i].w));
            chk({tag, "_bias"}, 64'(a_ev[i].b), 64'(exp_q[i].b));
            chk({tag, "_scale"}, 64'(a_ev[i].s), 64'(exp_q[i].s));
            chk({tag, "_ch"}, 64'(a_ev[i].ch), 64'(exp_q[i].ch));
            chk({tag, "_pix"}, 64'(a_ev[i].pix), 64'(exp_q[i].pix));
        end
    endtask

    // drives one run of instance a for 64 cycles plus a quiet tail
    task automatic run(input logic [63:0] spat, input int start2,
                       input int rst_at, output int n0);
        a_ev.delete();
        a_done_q.delete();
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) n0 = cyc;
            a_start = (k == 0) || (k == start2);
            a_stall = spat[k];
            if (k == rst_at) begin
                chk("pre_rst_busy", 64'(a_busy), 64'd1);
                chk("pre_rst_conv", 64'(a_conv11_en), 64'd1);
                chk("pre_rst_rd", 64'(a_fm_rd_en), 64'd1);
                rst = 1'b0;
                #1;
                chk("rst_busy", 64'(a_busy), 64'd0);
                chk("rst_conv", 64'(a_conv11_en), 64'd0);
                chk("rst_rd", 64'(a_fm_rd_en), 64'd0);
            end else begin
                rst = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic chk_done(input string tag, input int n0, input int dly);
        chk({tag, "_ndone"}, 64'(a_done_q.size()), 64'd1);
        if (a_done_q.size() == 1) begin
            if (dly >= 0)
                chk({tag, "_done_at"}, 64'(a_done_q[0] - n0), 64'(dly));
            if (a_ev.size() > 0)
                chk({tag, "_last_le_done"},
                    64'(a_ev[a_ev.size()-1].cyc <= a_done_q[0]), 64'd1);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 4; i++) fm[i] = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            wm[i] = 8'($urandom);
            bm[i] = $urandom;
            sm[i] = $urandom;
        end
    endtask

    initial begin
        int          n0;
        logic [63:0] spat;

        rst = 1'b0;
        a_start = 1'b0;
        a_stall = 1'b0;
        b_start = 1'b0;
        b_stall = 1'b0;
        fm = '{8'd5, 8'hFD, 8'h7F, 8'h80};
        wm = '{8'd2, 8'hFF};
        bm = '{32'd10, 32'd0};
        sm = '{32'd1, 32'd3};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(a_busy), 64'd0);
        chk("reset_done", 64'(a_done), 64'd0);
        chk("reset_conv", 64'(a_conv11_en), 64'd0);
        chk("reset_fm_rd", 64'(a_fm_rd_en), 64'd0);
        chk("reset_par_rd", 64'(a_par_rd_en), 64'd0);
        chk("reset_data", 64'(a_data_0_0), 64'd0);
        chk("reset_weight", 64'(a_weight_0), 64'd0);
        chk("reset_bias", 64'(a_bias), 64'd0);
        chk("reset_pix", 64'(a_pix_idx), 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run(64'd0, -1, -1, n0);
        cmp_events("basic");
        chk_done("basic", n0, 17);
        if (a_ev.size() > 0)
            chk("basic_first_lat", 64'(a_ev[0].cyc - n0), 64'd5);

        spat = 64'd0;
        spat[7:5] = 3'b111;
        run(spat, -1, -1, n0);
        cmp_events("stall");
        chk_done("stall", n0, 20);
        if (a_ev.size() > 2)
            chk("stall_gap", 64'(a_ev[2].cyc - a_ev[1].cyc), 64'd4);

        run(64'd0, 4, -1, n0);
        cmp_events("restart");
        chk_done("restart", n0, 17);

        spat = 64'd0;
        spat[2:1] = 2'b11;
        spat[10:7] = 4'b1111;
        spat[16:15] = 2'b11;
        run(spat, -1, -1, n0);
        cmp_events("ctl_stall");
        chk_done("ctl_stall", n0, 17);

        run(64'd0, -1, 13, n0);
        chk("midrst_ndone", 64'(a_done_q.size()), 64'd0);
        chk("midrst_idle", 64'(a_busy), 64'd0);

        rand_mem();
        run(64'd0, -1, -1, n0);
        cmp_events("after_rst");
        chk_done("after_rst", n0, 17);

        for (int it = 0; it < 4; it++) begin
            rand_mem();
            spat = {$urandom, $urandom} & {$urandom, $urandom};
            run(spat, -1, -1, n0);
            cmp_events("rand");
            chk_done("rand", n0, -1);
            if (a_done_q.size() == 1)
                chk("rand_done_min", 64'(a_done_q[0] - n0 >= 17), 64'd1);
        end

        b_rd_q.delete();
        b_conv_q.delete();
        b_done_q.delete();
        @(posedge clk);
        #1;
        n0 = cyc;
        b_start = 1'b1;
        b_stall = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        b_stall = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("one_nrd", 64'(b_rd_q.size()), 64'd1);
        chk("one_nconv", 64'(b_conv_q.size()), 64'd1);
        chk("one_ndone", 64'(b_done_q.size()), 64'd1);
        if (b_rd_q.size() == 1 && b_conv_q.size() == 1)
            chk("one_lat", 64'(b_conv_q[0] - b_rd_q[0]), 64'd2);
        if (b_done_q.size() == 1)
            chk("one_done_at", 64'(b_done_q[0] - n0), 64'd6);
        chk("one_data", 64'(b_data_0_0), 64'(fm[0]));
        chk("one_weight", 64'(b_weight_0), 64'(wm[0]));
        chk("one_idle", 64'(b_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
